serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to load operands and begin a serial add.
REQ-005 Port: a  input  WIDTH  parallel operand A, sampled on the accepted start edge.
REQ-006 Port: b  input  WIDTH  parallel operand B, sampled on the accepted start edge.
REQ-007 Port: cin  input  1  carry-in, sampled on the accepted start edge.
REQ-008 Port: busy  output  1  high while a serial add is in progress.
REQ-009 Port: sum_bit  output  1  current serial sum bit, LSB first.
REQ-010 Port: sum_vld  output  1  qualifies sum_bit; high for exactly WIDTH consecutive cycles per operation.
REQ-011 Port: result  output  WIDTH  parallel sum; held until the next completion or reset.
REQ-012 Port: cout  output  1  final carry-out; held with result.
REQ-013 Port: done  output  1  single-cycle pulse marking that result and cout are updated.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; the only legal transitions are IDLE->SHIFT, SHIFT->SHIFT, SHIFT->DONE and DONE->IDLE.
REQ-015 IDLE->SHIFT on a rising edge with start=1; that edge loads a and b into shift registers, loads cin into the carry flop and clears the bit counter.
REQ-016 SHIFT: each cycle, sum_bit=a_sh[0]^b_sh[0]^carry and sum_vld=1; on the edge, carry takes the majority of the three bits, both operand registers shift right by 1, and sum_bit shifts into the MSB of the sum shift register.
REQ-017 SHIFT->DONE after WIDTH cycles in SHIFT, when the counter reaches WIDTH-1.
REQ-018 DONE lasts exactly one cycle: done=1, result=assembled sum, cout=carry; it then returns to IDLE.
REQ-019 Latency: if start is accepted at edge t0, busy=1 during cycles t0+1..t0+WIDTH and done=1 in cycle t0+WIDTH+1.
REQ-020 start is accepted only in IDLE; start in SHIFT or DONE is ignored with no queuing, and operands are unaffected.
REQ-021 Back-to-back operation: start held high is accepted on the first IDLE edge after DONE, giving a WIDTH+2 cycle period.
REQ-022 Arithmetic: {cout,result} equals a+b+cin modulo 2^(WIDTH+1); all-ones operands plus cin=1 gives cout=1 and result=all-ones.
REQ-023 Outside SHIFT, sum_vld=0 and sum_bit=0.
REQ-024 a, b and cin are don't-care except on the accepted start edge.

Reset
REQ-025 rst=1 forces IDLE immediately with no clock required: busy, sum_bit, sum_vld, done, cout, carry and the counter are 0, and result is all zeros.
REQ-026 Reset mid-operation aborts without a done pulse; result and cout read 0, not partial data.
REQ-027 The first start is accepted on the first rising edge with rst=0 and start=1.

Configuration
REQ-028 Macro SERIAL_ADD_CTRL_OVF_EN: when defined, the block adds output ovf (1 bit), set in DONE to the signed two's-complement overflow (carry into MSB XOR carry out of MSB) and held with result.
REQ-029 ovf resets to 0.
REQ-030 When SERIAL_ADD_CTRL_OVF_EN is undefined, the ovf port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=4)
REQ-031 Case 1: a=1111, b=1100, cin=0 -> sum_bit stream 1,1,0,1 (LSB first), then done with result=1011 and cout=1.
REQ-032 Case 2: a=1000, b=0110, cin=1 -> result=1111, cout=0, done exactly 5 cycles after the start edge.
REQ-033 Case 3: a=1111, b=0000, cin=1 -> result=0000, cout=1; with OVF_EN, a=0111, b=0001, cin=0 -> result=1000, ovf=1.
REQ-034 Case 4: start pulsed again 2 cycles after acceptance with different operands -> ignored, the first result is unchanged, and a single done pulse occurs.
REQ-035 Case 5: rst asserted between clock edges during the 3rd SHIFT cycle -> busy=0 immediately, no done pulse, result=0000; a fresh start is then accepted normally.
REQ-036 Case 6: start held high for 3 operations -> done at a period of 6 cycles, each result correct.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: loads two operands, adds them LSB first, then presents the parallel sum.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_CTRL_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             sum_bit,
  output logic             sum_vld,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef SERIAL_ADD_CTRL_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_now;
  logic             carry_nxt;
  logic             last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and full-adder slice
  always_comb begin
    state_nxt = state;
    sum_now   = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last      = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register; sum_bit is gated to zero outside SHIFT
  always_comb begin
    busy    = 1'b0;
    sum_vld = 1'b0;
    sum_bit = 1'b0;
    done    = 1'b0;
    case (state)
      SHIFT: begin
        busy    = 1'b1;
        sum_vld = 1'b1;
        sum_bit = sum_now;
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // Operand/sum shift registers, carry, bit counter and held results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {sum_now, sum_sh[WIDTH-1:1]};
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          // The final bit is still in flight, so the result is assembled from it directly
          if (last) begin
            result <= {sum_now, sum_sh[WIDTH-1:1]};
            cout   <= carry_nxt;
`ifdef SERIAL_ADD_CTRL_OVF_EN
            ovf    <= carry ^ carry_nxt;
`endif
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule
